// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: snoops a multiplexed active-low 7-segment bus.
// Each digit's dwell is debounced and decoded back to BCD. The digits are
// gathered into a full frame, which is then presented with a one-cycle
// valid strobe.
module seg7_scan_capture #(
  parameter int unsigned NDIGITS       = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             seg_in,
  input  logic [NDIGITS-1:0]     an_in,
  output logic [4*NDIGITS-1:0]   bcd_out,
  output logic [NDIGITS-1:0]     blank_out,
  output logic                   frame_valid,
  output logic                   frame_err
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CYCLES - 1);

  // Sample register S and debounce state
  logic [NDIGITS-1:0]   an_q;
  logic [6:0]           seg_q;
  logic [CW-1:0]        cnt_q, cnt_d;

  // Frame assembly state
  logic [NDIGITS-1:0]   seen_q, seen_d;
  logic                 err_q, err_d;
  logic [4*NDIGITS-1:0] shadow_q, shadow_d;
  logic [NDIGITS-1:0]   shblank_q, shblank_d;

  // Registered outputs
  logic [4*NDIGITS-1:0] bcd_q, bcd_d;
  logic [NDIGITS-1:0]   blank_q, blank_d;
  logic                 fvalid_q, fvalid_d;
  logic                 ferr_q, ferr_d;

  // Decoded view of the incoming pattern
  logic [3:0]           dec_nib;
  logic                 dec_blank;
  logic                 dec_inv;

  logic                 in_onehot;
  logic                 same;
  logic                 capture;
  logic [NDIGITS-1:0]   cap_mask;
  logic                 frame_done;

  // The decimal point plays no part in capture or debounce.
  logic                 unused_dp;
  assign unused_dp = seg_in[7];

  // Inverse of the BCD->7-seg encoder (active low, abcdefg)
  always_comb begin
    dec_nib   = 4'hF;
    dec_blank = 1'b0;
    dec_inv   = 1'b0;
    unique case (seg_in[6:0])
      7'b0000001: dec_nib = 4'd0;
      7'b1001111: dec_nib = 4'd1;
      7'b0010010: dec_nib = 4'd2;
      7'b0000110: dec_nib = 4'd3;
      7'b1001100: dec_nib = 4'd4;
      7'b0100100: dec_nib = 4'd5;
      7'b0100000: dec_nib = 4'd6;
      7'b0001111: dec_nib = 4'd7;
      7'b0000000: dec_nib = 4'd8;
      7'b0000100: dec_nib = 4'd9;
      7'b1111111: begin
        dec_nib   = 4'd0;
        dec_blank = 1'b1;
      end
      default: begin
        dec_nib = 4'hF;
        dec_inv = 1'b1;
      end
    endcase
  end

  // Debounce: count consecutive identical valid samples, fire capture once per dwell.
  // The count covers the sample being taken on this edge. A fresh sample
  // therefore restarts the count at 1, and the STABLE_CYCLES-th identical
  // sample is the one that triggers the capture.
  always_comb begin
    in_onehot = $onehot(~an_in);
    same      = (an_in == an_q) && (seg_in[6:0] == seg_q);
    cnt_d     = '0;
    if (in_onehot) begin
      if (!same)                cnt_d = CW'(1);
      else if (cnt_q == CNT_MAX) cnt_d = CNT_MAX;
      else                      cnt_d = cnt_q + CW'(1);
    end
    capture  = in_onehot && same && (cnt_q == CNT_PRE);
    cap_mask = capture ? ~an_in : '0;
  end

  // Frame assembly: a capture on the completion edge belongs to the next frame
  always_comb begin
    frame_done = &seen_q;
    seen_d     = (frame_done ? '0 : seen_q) | cap_mask;
    err_d      = (frame_done ? 1'b0 : err_q) | (capture & dec_inv);
    shadow_d   = shadow_q;
    shblank_d  = shblank_q;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      if (cap_mask[i]) begin
        shadow_d[4*i +: 4] = dec_nib;
        shblank_d[i]       = dec_blank;
      end
    end
    bcd_d    = bcd_q;
    blank_d  = blank_q;
    ferr_d   = ferr_q;
    fvalid_d = frame_done;
    if (frame_done) begin
      bcd_d   = shadow_q;
      blank_d = shblank_q;
      ferr_d  = err_q;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      an_q      <= '0;
      seg_q     <= '0;
      cnt_q     <= '0;
      seen_q    <= '0;
      err_q     <= 1'b0;
      shadow_q  <= '0;
      shblank_q <= '0;
      bcd_q     <= '0;
      blank_q   <= '0;
      fvalid_q  <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      an_q      <= an_in;
      seg_q     <= seg_in[6:0];
      cnt_q     <= cnt_d;
      seen_q    <= seen_d;
      err_q     <= err_d;
      shadow_q  <= shadow_d;
      shblank_q <= shblank_d;
      bcd_q     <= bcd_d;
      blank_q   <= blank_d;
      fvalid_q  <= fvalid_d;
      ferr_q    <= ferr_d;
    end
  end

  assign bcd_out     = bcd_q;
  assign blank_out   = blank_q;
  assign frame_valid = fvalid_q;
  assign frame_err   = ferr_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed self-checking bench for seg7_scan_capture (4 digits, 4-sample debounce).
module tb_seg7_scan_capture;

  logic        clk;
  logic        rst;
  logic [7:0]  seg_in;
  logic [3:0]  an_in;
  logic [15:0] bcd_out;
  logic [3:0]  blank_out;
  logic        frame_valid;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  int fv_cnt = 0;
  int fv_base;

  localparam logic [6:0] PAT [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] BAD   = 7'b1010101;

  seg7_scan_capture #(.NDIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_in     (seg_in),
    .an_in      (an_in),
    .bcd_out    (bcd_out),
    .blank_out  (blank_out),
    .frame_valid(frame_valid),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every cycle in which frame_valid is high
  always @(negedge clk) if (frame_valid) fv_cnt++;

  // Hold one digit enabled with the given pattern for n samples
  task automatic dwell(input int d, input logic [6:0] p, input int n, input bit dp_toggle);
    logic [3:0] one;
    one   = 4'b0001;
    an_in = ~(one << d);
    for (int k = 0; k < n; k++) begin
      seg_in = {dp_toggle ? k[0] : 1'b1, p};
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    an_in  = '1;
    seg_in = '1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    an_in = '1;
    seg_in = '1;
    repeat (3) @(negedge clk);
    checks++;
    if (bcd_out !== 16'h0000 || blank_out !== 4'b0000 || frame_valid !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got bcd=%h blank=%b fv=%b err=%b exp all zero", bcd_out, blank_out, frame_valid, frame_err);
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_basic_latency;
    fv_base = fv_cnt;
    dwell(0, PAT[1], 8, 0);
    dwell(1, PAT[2], 8, 0);
    dwell(2, PAT[3], 8, 0);
    dwell(3, PAT[4], 4, 0);
    checks++;
    if (frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early got fv=%b exp 0", frame_valid);
    end
    @(negedge clk);
    checks++;
    if (frame_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency_on_time got fv=%b exp 1", frame_valid);
    end
    dwell(3, PAT[4], 3, 0);
    idle(6);
    checks++;
    if (fv_cnt - fv_base !== 1) begin
      errors++;
      $display("FAIL basic_frames got %0d exp 1", fv_cnt - fv_base);
    end
    checks++;
    if (bcd_out !== 16'h4321 || blank_out !== 4'b0000 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_data got bcd=%h blank=%b err=%b exp 4321 0000 0", bcd_out, blank_out, frame_err);
    end
  endtask

  task automatic test_short_dwell;
    fv_base = fv_cnt;
    dwell(0, PAT[5], 8, 0);
    dwell(1, PAT[6], 8, 0);
    dwell(2, PAT[7], 3, 0);
    dwell(3, PAT[8], 8, 0);
    idle(8);
    checks++;
    if (fv_cnt - fv_base !== 0) begin
      errors++;
      $display("FAIL short_no_frame got %0d exp 0", fv_cnt - fv_base);
    end
    dwell(2, PAT[7], 4, 0);
    idle(6);
    checks++;
    if (fv_cnt - fv_base !== 1) begin
      errors++;
      $display("FAIL short_then_frame got %0d exp 1", fv_cnt - fv_base);
    end
    checks++;
    if (bcd_out !== 16'h8765 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL short_data got bcd=%h err=%b exp 8765 0", bcd_out, frame_err);
    end
  endtask

  task automatic test_blank;
    fv_base = fv_cnt;
    dwell(0, PAT[0], 8, 0);
    dwell(1, BLANK, 8, 0);
    dwell(2, PAT[0], 8, 0);
    dwell(3, PAT[0], 8, 0);
    idle(6);
    checks++;
    if (fv_cnt - fv_base !== 1) begin
      errors++;
      $display("FAIL blank_frames got %0d exp 1", fv_cnt - fv_base);
    end
    checks++;
    if (bcd_out !== 16'h0000 || blank_out !== 4'b0010 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL blank_data got bcd=%h blank=%b err=%b exp 0000 0010 0", bcd_out, blank_out, frame_err);
    end
  endtask

  task automatic test_invalid;
    dwell(0, PAT[1], 8, 0);
    dwell(1, PAT[2], 8, 0);
    dwell(2, PAT[3], 8, 0);
    dwell(3, BAD, 8, 0);
    idle(6);
    checks++;
    if (bcd_out !== 16'hF321 || blank_out !== 4'b0000 || frame_err !== 1'b1) begin
      errors++;
      $display("FAIL invalid_data got bcd=%h blank=%b err=%b exp F321 0000 1", bcd_out, blank_out, frame_err);
    end
    dwell(0, PAT[9], 8, 0);
    dwell(1, PAT[9], 8, 0);
    dwell(2, PAT[9], 8, 0);
    dwell(3, PAT[9], 8, 0);
    idle(6);
    checks++;
    if (bcd_out !== 16'h9999 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL clean_after_err got bcd=%h err=%b exp 9999 0", bcd_out, frame_err);
    end
  endtask

  task automatic test_glitch;
    fv_base = fv_cnt;
    an_in  = 4'b0011;
    seg_in = {1'b1, PAT[0]};
    repeat (20) @(negedge clk);
    idle(2);
    checks++;
    if (fv_cnt - fv_base !== 0) begin
      errors++;
      $display("FAIL two_low_no_frame got %0d exp 0", fv_cnt - fv_base);
    end
    dwell(0, PAT[1], 8, 1);
    dwell(1, PAT[2], 8, 0);
    dwell(2, PAT[3], 8, 0);
    dwell(3, PAT[4], 3, 0);
    dwell(3, PAT[8], 1, 0);
    dwell(3, PAT[4], 3, 0);
    checks++;
    if (fv_cnt - fv_base !== 0) begin
      errors++;
      $display("FAIL glitch_restart got %0d exp 0", fv_cnt - fv_base);
    end
    dwell(3, PAT[4], 5, 0);
    idle(6);
    checks++;
    if (fv_cnt - fv_base !== 1) begin
      errors++;
      $display("FAIL glitch_single_frame got %0d exp 1", fv_cnt - fv_base);
    end
    checks++;
    if (bcd_out !== 16'h4321 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL glitch_data got bcd=%h err=%b exp 4321 0", bcd_out, frame_err);
    end
  endtask

  task automatic test_reset_midframe;
    fv_base = fv_cnt;
    dwell(0, PAT[1], 8, 0);
    dwell(1, PAT[1], 8, 0);
    dwell(3, PAT[1], 8, 0);
    rst = 1'b1;
    idle(3);
    checks++;
    if (bcd_out !== 16'h0000 || blank_out !== 4'b0000 || frame_valid !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs got bcd=%h blank=%b fv=%b err=%b exp all zero", bcd_out, blank_out, frame_valid, frame_err);
    end
    rst = 1'b0;
    dwell(0, PAT[9], 8, 0);
    dwell(1, PAT[8], 8, 0);
    dwell(2, PAT[7], 8, 0);
    idle(6);
    checks++;
    if (fv_cnt - fv_base !== 0) begin
      errors++;
      $display("FAIL midreset_seen_cleared got %0d exp 0", fv_cnt - fv_base);
    end
    dwell(3, PAT[6], 8, 0);
    idle(6);
    checks++;
    if (fv_cnt - fv_base !== 1) begin
      errors++;
      $display("FAIL midreset_frames got %0d exp 1", fv_cnt - fv_base);
    end
    checks++;
    if (bcd_out !== 16'h6789 || blank_out !== 4'b0000 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL midreset_data got bcd=%h blank=%b err=%b exp 6789 0000 0", bcd_out, blank_out, frame_err);
    end
  endtask

  initial begin
    test_reset;
    test_basic_latency;
    test_short_dwell;
    test_blank;
    test_invalid;
    test_glitch;
    test_reset_midframe;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
